// File: rtl/fir_pkg.sv
// Shared defaults and width helpers for the parameterised FIR filter.
package fir_pkg;

  localparam int unsigned FIR_NTAPS = 11;
  localparam int unsigned FIR_DW    = 8;
  localparam int unsigned FIR_CW    = 8;
  localparam int unsigned FIR_SAT   = 1;

  // Accumulator holds NTAPS full-width products without overflow.
  function automatic int unsigned fir_acc_w(input int unsigned ntaps,
                                            input int unsigned dw,
                                            input int unsigned cw);
    return dw + cw + $clog2(ntaps);
  endfunction

  // Q1.(CW-1) coefficients: drop CW-1 fraction bits to return to sample scale.
  function automatic int unsigned fir_shift(input int unsigned cw);
    return cw - 1;
  endfunction

  localparam int unsigned FIR_ACCW  = fir_acc_w(FIR_NTAPS, FIR_DW, FIR_CW);
  localparam int unsigned FIR_SHIFT = fir_shift(FIR_CW);

endpackage

// File: rtl/fir_coef_bank.sv
// Double-buffered coefficient storage: shadow bank written per index,
// active bank loaded from shadow in one cycle on commit (write-first).
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int unsigned NTAPS = FIR_NTAPS,
  parameter int unsigned CW    = FIR_CW
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_we,
  input  logic [$clog2(NTAPS)-1:0]  i_addr,
  input  logic [CW-1:0]             i_data,
  input  logic                      i_commit,
  output logic [NTAPS*CW-1:0]       o_active
);

  localparam int unsigned AW = $clog2(NTAPS);

  logic [CW-1:0]       r_shadow [NTAPS];
  logic [NTAPS*CW-1:0] r_active;
  logic [NTAPS-1:0]    w_hit;

  // Out-of-range addresses match no tap and are dropped.
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < NTAPS; i++) begin
      w_hit[i] = i_we && (i_addr == AW'(i));
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NTAPS; i++) begin
        r_shadow[i] <= '0;
      end
      r_active <= '0;
    end else begin
      for (int i = 0; i < NTAPS; i++) begin
        if (w_hit[i]) begin
          r_shadow[i] <= i_data;
        end
        if (i_commit) begin
          r_active[i*CW +: CW] <= w_hit[i] ? i_data : r_shadow[i];
        end
      end
    end
  end

  assign o_active = r_active;

endmodule

// File: rtl/fir_param.sv
// Parameterised direct-form FIR: delay line, registered products, registered
// sum, then scaled/saturated-or-wrapped output. Latency 3 cycles, no stalls.
module fir_param
  import fir_pkg::*;
#(
  parameter int unsigned NTAPS = FIR_NTAPS,
  parameter int unsigned DW    = FIR_DW,
  parameter int unsigned CW    = FIR_CW,
  parameter int unsigned SAT   = FIR_SAT
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DW-1:0]             DIN,
  input  logic                      VIN,
  input  logic                      C_WE,
  input  logic [$clog2(NTAPS)-1:0]  C_ADDR,
  input  logic [CW-1:0]             C_DATA,
  input  logic                      C_COMMIT,
  output logic [DW-1:0]             DOUT,
  output logic                      VOUT,
  output logic                      OVF
);

  localparam int unsigned PW    = DW + CW;
  localparam int unsigned ACCW  = fir_acc_w(NTAPS, DW, CW);
  localparam int unsigned SHIFT = fir_shift(CW);
  localparam int unsigned TW    = ACCW - DW + 1;

  logic [NTAPS*CW-1:0]    w_coef;
  logic signed [CW-1:0]   w_b    [NTAPS];
  logic signed [DW-1:0]   r_x    [NTAPS];
  logic signed [PW-1:0]   r_prod [NTAPS];
  logic signed [ACCW-1:0] r_acc;
  logic signed [ACCW-1:0] w_sum;
  logic signed [ACCW-1:0] w_shift;
  logic [TW-1:0]          w_top;
  logic                   w_ovf;
  logic [DW-1:0]          w_dout;
  logic                   r_v0, r_v1, r_v2;
  logic [DW-1:0]          r_dout;
  logic                   r_vout, r_ovf;

  fir_coef_bank #(
    .NTAPS (NTAPS),
    .CW    (CW)
  ) u_coef_bank (
    .i_clk    (CLK),
    .i_rst    (RST),
    .i_we     (C_WE),
    .i_addr   (C_ADDR),
    .i_data   (C_DATA),
    .i_commit (C_COMMIT),
    .o_active (w_coef)
  );

  always_comb begin
    for (int i = 0; i < NTAPS; i++) begin
      w_b[i] = w_coef[i*CW +: CW];
    end
  end

  // Stage 0: delay line advances only on accepted samples.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NTAPS; i++) begin
        r_x[i] <= '0;
      end
      r_v0 <= 1'b0;
    end else begin
      r_v0 <= VIN;
      if (VIN) begin
        r_x[0] <= DIN;
        for (int i = 1; i < NTAPS; i++) begin
          r_x[i] <= r_x[i-1];
        end
      end
    end
  end

  // Stage 1: full-width products against the bank active for this sample.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NTAPS; i++) begin
        r_prod[i] <= '0;
      end
      r_v1 <= 1'b0;
    end else begin
      r_v1 <= r_v0;
      if (r_v0) begin
        for (int i = 0; i < NTAPS; i++) begin
          r_prod[i] <= PW'(w_b[i]) * PW'(r_x[i]);
        end
      end
    end
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NTAPS; i++) begin
      w_sum = w_sum + ACCW'(r_prod[i]);
    end
  end

  // Stage 2: accumulate.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_acc <= '0;
      r_v2  <= 1'b0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_acc <= w_sum;
      end
    end
  end

  // Out of range exactly when the bits above the result are not a sign extension.
  always_comb begin
    w_shift = r_acc >>> SHIFT;
    w_top   = w_shift[ACCW-1:DW-1];
    w_ovf   = !((&w_top) || !(|w_top));
    w_dout  = w_shift[DW-1:0];
    if (SAT != 0 && w_ovf) begin
      w_dout = w_top[TW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end
  end

  // Stage 3: output register; DOUT holds between valid samples.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_dout <= '0;
      r_vout <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_vout <= r_v2;
      r_ovf  <= r_v2 && w_ovf;
      if (r_v2) begin
        r_dout <= w_dout;
      end
    end
  end

  assign DOUT = r_dout;
  assign VOUT = r_vout;
  assign OVF  = r_ovf;

endmodule

// File: tb/tb_fir_param.sv
// Directed bench for fir_param: a saturating and a wrapping instance share
// all inputs; outputs are checked against hand-computed values every cycle.
module tb_fir_param;

  logic       clk = 1'b0;
  logic       rst, vin, c_we, c_commit;
  logic [7:0] din, c_data;
  logic [3:0] c_addr;
  logic [7:0] dout_s, dout_w;
  logic       vout_s, vout_w, ovf_s, ovf_w;

  always #5 clk = ~clk;

  fir_param #(.NTAPS(11), .DW(8), .CW(8), .SAT(1)) u_sat (
    .CLK(clk), .RST(rst), .DIN(din), .VIN(vin), .C_WE(c_we), .C_ADDR(c_addr),
    .C_DATA(c_data), .C_COMMIT(c_commit), .DOUT(dout_s), .VOUT(vout_s), .OVF(ovf_s)
  );

  fir_param #(.NTAPS(11), .DW(8), .CW(8), .SAT(0)) u_wrap (
    .CLK(clk), .RST(rst), .DIN(din), .VIN(vin), .C_WE(c_we), .C_ADDR(c_addr),
    .C_DATA(c_data), .C_COMMIT(c_commit), .DOUT(dout_w), .VOUT(vout_w), .OVF(ovf_w)
  );

  typedef struct {
    logic rst;
    logic vin;
    int   din;
    logic we;
    int   addr;
    int   data;
    logic commit;
    logic ev;
    int   ed;
    logic eo;
  } vec_t;

  vec_t tbl [64];
  int   nv = 0;
  int   checks = 0;
  int   failures = 0;
  int   imp [11] = '{0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5};

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input int d, input logic we,
                       input int a, input int data, input logic cm);
    @(negedge clk);
    rst = r; vin = v; din = 8'(d); c_we = we; c_addr = 4'(a);
    c_data = 8'(data); c_commit = cm;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string nm, input int ev, input int ed_s, input int eo_s,
                            input int ed_w, input int eo_w);
    chk({nm, " vout_s"}, int'(vout_s), ev);
    chk({nm, " vout_w"}, int'(vout_w), ev);
    chk({nm, " dout_s"}, int'($signed(dout_s)), ed_s);
    chk({nm, " ovf_s"},  int'(ovf_s), eo_s);
    chk({nm, " dout_w"}, int'($signed(dout_w)), ed_w);
    chk({nm, " ovf_w"},  int'(ovf_w), eo_w);
  endtask

  task automatic add(input logic r, input logic v, input int d, input logic we, input int a,
                     input int data, input logic cm, input logic ev, input int ed);
    tbl[nv] = '{rst: r, vin: v, din: d, we: we, addr: a, data: data, commit: cm,
                ev: ev, ed: ed, eo: 1'b0};
    nv++;
  endtask

  // Single 64 followed by zeros; DOUT reproduces (i+1)*64 >> 7 per tap.
  task automatic add_impulse(input int prev);
    for (int r = 0; r < 14; r++) begin
      if (r >= 3) add(1'b0, r < 11, (r == 0) ? 64 : 0, 1'b0, 0, 0, 1'b0, 1'b1, imp[r-3]);
      else        add(1'b0, r < 11, (r == 0) ? 64 : 0, 1'b0, 0, 0, 1'b0, 1'b0, prev);
    end
  endtask

  task automatic flush();
    for (int c = 0; c < 15; c++) drive(1'b0, c < 11, 0, 1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    int last;
    int s;
    logic ev;
    rst = 1'b1; vin = 1'b0; din = '0; c_we = 1'b0; c_addr = '0; c_data = '0; c_commit = 1'b0;

    // Reset, load b_i = i+1 with the final write and commit together, impulse,
    // then out-of-range writes + commit must leave the bank untouched.
    add(1'b1, 1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 11; i++) add(1'b0, 1'b0, 0, 1'b1, i, i + 1, i == 10, 1'b0, 0);
    add_impulse(0);
    add(1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0, 5);
    for (int a = 11; a < 16; a++) add(1'b0, 1'b0, 0, 1'b1, a, -128, 1'b0, 1'b0, 5);
    add(1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b1, 1'b0, 5);
    add_impulse(5);

    for (int i = 0; i < nv; i++) begin
      drive(tbl[i].rst, tbl[i].vin, tbl[i].din, tbl[i].we, tbl[i].addr, tbl[i].data,
            tbl[i].commit);
      expect_out($sformatf("tbl%0d", i), int'(tbl[i].ev), tbl[i].ed, int'(tbl[i].eo),
                 tbl[i].ed, int'(tbl[i].eo));
    end

    // Same impulse with VIN every third cycle.
    flush();
    expect_out("flush", 0, 0, 0, 0, 0);
    last = 0;
    for (int c = 0; c < 36; c++) begin
      drive(1'b0, (c % 3 == 0) && (c < 33), (c == 0) ? 64 : 0, 1'b0, 0, 0, 1'b0);
      s  = c - 3;
      ev = (c >= 3) && (s % 3 == 0) && (s / 3 < 11);
      if (ev) last = imp[s / 3];
      expect_out($sformatf("gap%0d", c), int'(ev), last, 0, last, 0);
    end

    // b_i = 1 active, shadow b_i = 2 written mid-stream, commit with sample 15.
    for (int i = 0; i < 11; i++) drive(1'b0, 1'b0, 0, 1'b1, i, 1, i == 10);
    flush();
    last = 0;
    for (int c = 0; c < 24; c++) begin
      drive(1'b0, c < 20, 10, c < 11, c, 2, c == 15);
      s  = c - 3;
      ev = (c >= 3) && (s < 20);
      if (ev) last = (s >= 15) ? 1 : 0;
      expect_out($sformatf("commit%0d", c), int'(ev), last, 0, last, 0);
    end

    // All coefficients 127: full-scale positive then negative input.
    for (int i = 0; i < 11; i++) drive(1'b0, 1'b0, 0, 1'b1, i, 127, i == 10);
    for (int c = 0; c < 25; c++) begin
      drive(1'b0, c < 22, (c < 11) ? 127 : -128, 1'b0, 0, 0, 1'b0);
      if (c == 13) expect_out("sat_pos", 1, 127, 1, 106, 1);
      if (c == 24) expect_out("sat_neg", 1, -128, 1, -117, 1);
    end
    drive(1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b0);
    expect_out("sat_hold", 0, -128, 0, -117, 0);

    // Reset with two samples in flight (VIN also high at the reset edge).
    for (int c = 0; c < 6; c++) begin
      drive(c == 2, c < 3, 100, 1'b0, 0, 0, 1'b0);
      if (c < 2) expect_out($sformatf("rst%0d", c), 0, -128, 0, -117, 0);
      else       expect_out($sformatf("rst%0d", c), 0, 0, 0, 0, 0);
    end
    for (int c = 0; c < 14; c++) begin
      drive(1'b0, c < 11, 100, 1'b0, 0, 0, 1'b0);
      expect_out($sformatf("post%0d", c), int'(c >= 3), 0, 0, 0, 0);
    end
    drive(1'b0, 1'b1, 100, 1'b1, 0, 64, 1'b1);
    drive(1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b0);
    expect_out("recommit1", 0, 0, 0, 0, 0);
    drive(1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b0);
    expect_out("recommit2", 0, 0, 0, 0, 0);
    drive(1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b0);
    expect_out("recommit3", 1, 50, 0, 50, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
